// File: rtl/operand_entry_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// operand_entry_ctrl_pkg
// Shared definitions for the operand entry controller:
//   - state_t   : FSM states; the encoding doubles as the ms_out display code
//   - PAGE_*    : led_sel display page selects
//   - page_of() : maps a state to the display page it shows
// ---------------------------------------------------------------------------
package operand_entry_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'h0,
        ST_LOAD_A  = 4'h1,
        ST_LOAD_B  = 4'h2,
        ST_LOAD_OP = 4'h3,
        ST_RUN     = 4'h4,
        ST_SHOW    = 4'h5,
        ST_ERR     = 4'hE
    } state_t;

    localparam logic [1:0] PAGE_OPND  = 2'b00;
    localparam logic [1:0] PAGE_RES   = 2'b01;
    localparam logic [1:0] PAGE_STATE = 2'b10;

    function automatic logic [1:0] page_of(input state_t s);
        logic [1:0] page;
        page = PAGE_OPND;
        if (s == ST_SHOW) page = PAGE_RES;
        else if (s == ST_ERR) page = PAGE_STATE;
        return page;
    endfunction

endpackage

// File: rtl/operand_entry_ctrl_go_debounce.sv
// ---------------------------------------------------------------------------
// go_debounce
// Synchronizes the raw Go pushbutton, debounces it and emits a one-cycle
// pulse on each accepted rising edge of the debounced level.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   go_raw in  raw, bouncy button (asynchronous to clk)
//   go_p   out one-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module go_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic go_raw,
    output logic go_p
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [1:0]       sync_vld;
    logic             db_level;
    logic [CNT_W-1:0] db_cnt;
    logic             armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            sync_vld <= 2'b00;
            db_level <= 1'b0;
            db_cnt   <= '0;
            armed    <= 1'b0;
            go_p     <= 1'b0;
        end else begin
            // two-flop synchronizer
            sync_p0  <= go_raw;
            sync_p1  <= sync_p0;
            sync_vld <= {sync_vld[0], 1'b1};
            go_p     <= 1'b0;

            // counter only runs while the synchronized input disagrees
            // with the accepted level; DB_CYCLES disagreeing samples flip it
            if (sync_p1 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                db_cnt   <= '0;
                db_level <= sync_p1;
                go_p     <= sync_p1 & armed;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            // A button held through reset must be seen released before a
            // press counts; sync_vld masks the reset contents of the flops.
            if (sync_vld[1] && !sync_p1 && !db_level) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_entry_ctrl.sv
// ---------------------------------------------------------------------------
// operand_entry_ctrl
// Input-side controller of the calculator: walks the user through entering
// operand 1, operand 2 and the opcode with the Go button, starts the ALU and
// waits for completion or timeout. Drives the display interface.
// Ports:
//   clk50MHz  in  system clock
//   rst       in  asynchronous active-high reset
//   sw        in  operand switches
//   op_sw     in  opcode switches
//   go_raw    in  raw Go pushbutton
//   alu_done  in  ALU completion (sampled only in RUN)
//   in1, in2  out latched operands to ALU
//   op        out latched opcode to ALU
//   alu_start out one-cycle ALU start pulse
//   din_dis1/2 out operand digits to display
//   ms_out    out state code to display
//   led_sel   out display page select
//   busy      out high while in RUN
// ---------------------------------------------------------------------------
module operand_entry_ctrl
    import operand_entry_ctrl_pkg::*;
#(
    parameter int DB_CYCLES      = 250000,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk50MHz,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic [2:0] op_sw,
    input  logic       go_raw,
    input  logic       alu_done,
    output logic [3:0] in1,
    output logic [3:0] in2,
    output logic [2:0] op,
    output logic       alu_start,
    output logic [3:0] din_dis1,
    output logic [3:0] din_dis2,
    output logic [3:0] ms_out,
    output logic [1:0] led_sel,
    output logic       busy
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] to_cnt;
    logic            go_p;
    logic            ld_in1;
    logic            ld_in2;
    logic            start_d;

    go_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_go_db (
        .clk    (clk50MHz),
        .rst    (rst),
        .go_raw (go_raw),
        .go_p   (go_p)
    );

    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_in1  = 1'b0;
        ld_in2  = 1'b0;
        start_d = 1'b0;
        unique case (state_q)
            ST_IDLE:    if (go_p) state_d = ST_LOAD_A;
            ST_LOAD_A:  if (go_p) begin
                            ld_in1  = 1'b1;
                            state_d = ST_LOAD_B;
                        end
            ST_LOAD_B:  if (go_p) begin
                            ld_in2  = 1'b1;
                            state_d = ST_LOAD_OP;
                        end
            ST_LOAD_OP: if (go_p) begin
                            start_d = 1'b1;
                            state_d = ST_RUN;
                        end
            // completion has priority over a simultaneous timeout
            ST_RUN:     if (alu_done)               state_d = ST_SHOW;
                        else if (to_cnt == TO_LAST) state_d = ST_ERR;
            ST_SHOW,
            ST_ERR:     if (go_p) state_d = ST_LOAD_A;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Operand/opcode latches, timeout counter and registered display outputs
    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            in1       <= '0;
            in2       <= '0;
            op        <= '0;
            alu_start <= 1'b0;
            to_cnt    <= '0;
            din_dis1  <= '0;
            din_dis2  <= '0;
            ms_out    <= ST_IDLE;
            led_sel   <= PAGE_OPND;
            busy      <= 1'b0;
        end else begin
            if (ld_in1)  in1 <= sw;
            if (ld_in2)  in2 <= sw;
            if (start_d) op  <= op_sw;
            alu_start <= start_d;

            if (start_d)               to_cnt <= '0;
            else if (state_q == ST_RUN) to_cnt <= to_cnt + 1'b1;

            din_dis1 <= (state_q == ST_LOAD_A) ? sw : in1;
            din_dis2 <= (state_q == ST_LOAD_B) ? sw : in2;
            ms_out   <= state_q;
            led_sel  <= page_of(state_q);
            busy     <= (state_q == ST_RUN);
        end
    end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
module tb_operand_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic [2:0] op_sw;
    logic       go_raw;
    logic       alu_done;
    logic [3:0] in1, in2, din_dis1, din_dis2, ms_out;
    logic [2:0] op;
    logic [1:0] led_sel;
    logic       alu_start, busy;

    int tests  = 0;
    int failed = 0;
    int starts = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] opv;
    } opnd_t;
    opnd_t exp_q[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] opv;
        int         delay;    // negedges after busy seen before alu_done; -1 = never
        logic [3:0] exp_ms;
        logic [1:0] exp_led;
    } vec_t;
    vec_t vecs[5];

    operand_entry_ctrl #(
        .DB_CYCLES      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk50MHz  (clk),
        .rst       (rst),
        .sw        (sw),
        .op_sw     (op_sw),
        .go_raw    (go_raw),
        .alu_done  (alu_done),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .alu_start (alu_start),
        .din_dis1  (din_dis1),
        .din_dis2  (din_dis2),
        .ms_out    (ms_out),
        .led_sel   (led_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every alu_start must match the operands queued at the LOAD_OP press
    always @(negedge clk) begin
        if (!rst && alu_start) begin
            opnd_t e;
            starts++;
            if (exp_q.size() == 0) begin
                check("alu_start_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("start_in1", int'(in1), int'(e.a));
                check("start_in2", int'(in2), int'(e.b));
                check("start_op",  int'(op),  int'(e.opv));
            end
        end
    end

    // Hold Go until the expected state code shows (bounded), then release.
    task automatic press(input int exp_ms, input bit settle);
        int n;
        n = 0;
        go_raw = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (ms_out != 4'(exp_ms) && n < 30);
        check("press_ms_out", int'(ms_out), exp_ms);
        go_raw = 1'b0;
        if (settle) repeat (12) @(negedge clk);
    endtask

    task automatic run_txn(input vec_t v);
        int s0;
        sw = v.a;
        repeat (2) @(negedge clk);
        check("live_din_dis1", int'(din_dis1), int'(v.a));
        press(2, 1'b1);
        check("latched_in1", int'(in1), int'(v.a));
        sw = v.b;
        repeat (2) @(negedge clk);
        check("live_din_dis2", int'(din_dis2), int'(v.b));
        check("held_din_dis1", int'(din_dis1), int'(v.a));
        press(3, 1'b1);
        check("latched_in2", int'(in2), int'(v.b));
        op_sw = v.opv;
        exp_q.push_back('{v.a, v.b, v.opv});
        s0 = starts;
        press(4, 1'b0);
        check("busy_run", int'(busy), 1);
        check("led_run", int'(led_sel), 0);
        for (int k = 0; k < 20; k++) begin
            alu_done = (k == v.delay);
            @(negedge clk);
        end
        alu_done = 1'b0;
        check("end_ms_out", int'(ms_out), int'(v.exp_ms));
        check("end_led_sel", int'(led_sel), int'(v.exp_led));
        check("end_busy", int'(busy), 0);
        check("end_op", int'(op), int'(v.opv));
        check("end_din_dis2", int'(din_dis2), int'(v.b));
        check("start_count", starts - s0, 1);
        press(1, 1'b1);
        check("back_led_sel", int'(led_sel), 0);
    endtask

    initial begin
        int s0;
        vecs[0] = '{a: 4'd7,  b: 4'd9,  opv: 3'd3, delay: 5,  exp_ms: 4'h5, exp_led: 2'b01};
        vecs[1] = '{a: 4'd15, b: 4'd0,  opv: 3'd7, delay: -1, exp_ms: 4'hE, exp_led: 2'b10};
        vecs[2] = '{a: 4'd1,  b: 4'd14, opv: 3'd6, delay: 14, exp_ms: 4'h5, exp_led: 2'b01};
        vecs[3] = '{a: 4'd10, b: 4'd5,  opv: 3'd0, delay: 15, exp_ms: 4'hE, exp_led: 2'b10};
        vecs[4] = '{a: 4'd0,  b: 4'd15, opv: 3'd2, delay: 0,  exp_ms: 4'h5, exp_led: 2'b01};

        rst = 1'b1; sw = 4'd0; op_sw = 3'd0; go_raw = 1'b0; alu_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ms_out", int'(ms_out), 0);
        check("rst_led_sel", int'(led_sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in1", int'(in1), 0);
        check("rst_in2", int'(in2), 0);
        check("rst_op", int'(op), 0);
        check("rst_alu_start", int'(alu_start), 0);
        check("rst_din_dis1", int'(din_dis1), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // bounce: toggling every 2 cycles never satisfies the 4-sample debounce
        for (int i = 0; i < 10; i++) begin
            go_raw = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        check("bounce_no_accept", int'(ms_out), 0);
        go_raw = 1'b1;
        repeat (12) @(negedge clk);
        check("bounce_one_go", int'(ms_out), 1);
        go_raw = 1'b0;
        repeat (12) @(negedge clk);
        check("release_no_go", int'(ms_out), 1);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Go pressed again while RUN waits: ignored, nothing re-latched
        sw = 4'd3;
        press(2, 1'b1);
        sw = 4'd12;
        press(3, 1'b1);
        op_sw = 3'd5;
        exp_q.push_back('{4'd3, 4'd12, 3'd5});
        s0 = starts;
        go_raw = 1'b1;
        repeat (7) @(negedge clk);
        go_raw = 1'b0;
        repeat (6) @(negedge clk);
        go_raw = 1'b1;
        op_sw = 3'd2;
        sw = 4'd1;
        repeat (7) @(negedge clk);
        check("run_go_still_run", int'(ms_out), 4);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        go_raw = 1'b0;
        repeat (20) @(negedge clk);
        check("run_go_ms_out", int'(ms_out), 5);
        check("run_go_starts", starts - s0, 1);
        check("run_go_in1", int'(in1), 3);
        check("run_go_in2", int'(in2), 12);
        check("run_go_op", int'(op), 5);
        press(1, 1'b1);

        // async reset in LOAD_B with button held
        sw = 4'd7;
        press(2, 1'b1);
        check("pre_rst_in1", int'(in1), 7);
        go_raw = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ms_out", int'(ms_out), 0);
        check("arst_in1", int'(in1), 0);
        check("arst_din_dis1", int'(din_dis1), 0);
        check("arst_alu_start", int'(alu_start), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("held_no_go", int'(ms_out), 0);
        go_raw = 1'b0;
        repeat (12) @(negedge clk);
        check("release_no_go2", int'(ms_out), 0);
        press(1, 1'b1);

        check("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/operand_entry_ctrl.md
# operand_entry_ctrl

Input-side controller for the calculator datapath: debounces the raw Go pushbutton, walks the user through entering operand 1, operand 2 and the opcode from the slide switches, starts the ALU and waits for its completion. It produces the operand digits, the state code and the display-page select consumed by the display encasing level. It is the writer end of the Din/MS/LEDsel display interface and sits between the board switches/button and the ALU/display blocks in the top level.

## Interface
Parameters:
- DB_CYCLES, 250000, consecutive stable samples of go_raw required to accept a new level (5 ms at 50 MHz)
- TIMEOUT_CYCLES, 1024, cycles allowed in RUN for alu_done before error

Ports:
- clk50MHz  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- sw  in  4  operand switches (0–15)
- op_sw  in  3  opcode switches
- go_raw  in  1  raw, bouncy Go pushbutton, asynchronous to clk50MHz
- alu_done  in  1  ALU completion, level or pulse, sampled only in RUN
- in1, in2  out  4  latched operands to ALU
- op  out  3  latched opcode to ALU
- alu_start  out  1  one-cycle start pulse
- din_dis1, din_dis2  out  4  operand digits to display
- ms_out  out  4  state code to display
- led_sel  out  2  display page: 00 operands, 01 result, 10 state/error
- busy  out  1  high in RUN

## Operation
- go_raw passes a 2-flop synchronizer, then the debouncer; a rising edge of the debounced level gives go_p, exactly one cycle wide. Holding the button gives one go_p only.
- States (ms_out code): IDLE(0), LOAD_A(1), LOAD_B(2), LOAD_OP(3), RUN(4), SHOW(5), ERR(4'hE).
- IDLE: go_p → LOAD_A.
- LOAD_A: din_dis1 follows sw live; go_p → in1<=sw, → LOAD_B.
- LOAD_B: din_dis2 follows sw live, din_dis1 = in1; go_p → in2<=sw, → LOAD_OP.
- LOAD_OP: go_p → op<=op_sw, alu_start=1 for that one cycle, timeout counter cleared, → RUN.
- RUN: go_p ignored; alu_done=1 → SHOW; counter reaching TIMEOUT_CYCLES-1 without done → ERR. alu_done and timeout in same cycle: SHOW wins.
- SHOW: go_p → LOAD_A (in1/in2/op retained until overwritten).
- ERR: go_p → LOAD_A.
- Outside LOAD_A/LOAD_B, din_dis1=in1, din_dis2=in2.
- led_sel: 00 in IDLE/LOAD_A/LOAD_B/LOAD_OP/RUN, 01 in SHOW, 10 in ERR.

## Timing
- Reset values: in1=in2=0, op=0, alu_start=0, din_dis1=din_dis2=0, ms_out=0, led_sel=00, busy=0, state IDLE, debounced level 0, counters 0.
- All outputs registered; ms_out/led_sel/busy change the cycle after the state transition edge.
- Button-to-go_p latency: 2 sync cycles + DB_CYCLES + 1.
- alu_start asserts in the cycle after go_p is seen in LOAD_OP, together with in1/in2/op already stable (op registered same edge; ALU samples on following edge).
- RUN → SHOW one cycle after alu_done sampled high.
- Reset asserted mid-operation: immediate return to reset values, no alu_start glitch; a button held through reset release does not produce go_p until released and pressed again.
- Debounce counter resets whenever the synchronized input equals the current debounced level; width = clog2(DB_CYCLES).

## Structure
- Shared package: state encodings/ms_out codes, led_sel page constants (PAGE_OPND, PAGE_RES, PAGE_STATE).
- One sub-module: go_debounce (synchronizer + counter + rising-edge pulse), parameter DB_CYCLES; FSM, latches and timeout counter in the top of this block.

## Test plan
(Benches use DB_CYCLES=4, TIMEOUT_CYCLES=16.)
- Bounce: go_raw toggles every 2 cycles for 20 cycles then held 1 → exactly one go_p; IDLE→LOAD_A, ms_out=1.
- Full entry: sw=7 go, sw=9 go, op_sw=3 go → in1=7, in2=9, op=3, one alu_start pulse, ms_out=4, busy=1; alu_done after 5 cycles → ms_out=5, led_sel=01, busy=0.
- Timeout: no alu_done in RUN → ERR after 16 cycles, ms_out=E, led_sel=10; go → LOAD_A.
- Simultaneous: alu_done asserted on the 16th RUN cycle → SHOW, not ERR.
- Go in RUN pressed during wait → ignored, in1/in2/op unchanged, no second alu_start.
- Async reset in LOAD_B with in1=7 and button held → all outputs 0, IDLE; no go_p until button released and re-pressed.
